// File: rtl/axis_video_frame_ctrl.sv
// Gates a packed 48-bit pixel stream into an AXI4-Stream video master with SOF/EOL tags.
// Define AXIS_FRAME_DROP_EN to discard the remainder of a frame after a buffer overflow.
module axis_video_frame_ctrl #(
  parameter int LINE_BEATS  = 1920,
  parameter int FRAME_LINES = 2160,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic        sof_i,
  input  logic [47:0] pix_data_i,
  input  logic        pix_valid_i,
  input  logic        clr_i,
  output logic [47:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        busy_o,
  output logic        overflow_o,
  output logic [15:0] frame_cnt_o,
  output logic [1:0]  state_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_STREAM   = 2'd2;
  localparam logic [1:0] S_DROP     = 2'd3;

  localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 51;

  localparam logic [BW-1:0] BEAT_LAST = BW'(LINE_BEATS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(FRAME_LINES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

`ifdef AXIS_FRAME_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d, pos_beat;
  logic [LW-1:0] line_q, line_d, pos_line;
  logic          overflow_q, overflow_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  // Buffer entry: {tdata[47:0], tuser, tlast, end_of_frame}
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [EW-1:0] head, wr_entry;

  logic empty, full, rd_fire, take, wr_en, ovf_evt, end_beat, end_line;

  // Master handshake: a beat transfers on any edge where m_axis_tvalid & m_axis_tready;
  // tvalid never drops and the head never changes until that transfer happens.
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign rd_fire = !empty && m_axis_tready;
  assign head    = mem_q[rd_ptr_q];

  assign pos_beat = sof_i ? '0 : beat_q;
  assign pos_line = sof_i ? '0 : line_q;
  assign end_beat = (pos_beat == BEAT_LAST);
  assign end_line = (pos_line == LINE_LAST);
  assign wr_entry = {pix_data_i, (pos_beat == '0) && (pos_line == '0), end_beat,
                     end_beat && end_line};

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    take    = 1'b0;
    wr_en   = 1'b0;
    ovf_evt = 1'b0;
    case (state_q)
      S_IDLE: if (enable_i) state_d = S_WAIT_SOF;
      S_WAIT_SOF: begin
        if (!enable_i) state_d = S_IDLE;
        else if (pix_valid_i && sof_i) take = 1'b1;
      end
      S_STREAM: take = pix_valid_i;
      S_DROP: begin
        if (pix_valid_i && sof_i) begin
          if (enable_i) take = 1'b1;
          else state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      state_d = S_STREAM;
      if (end_beat) begin
        beat_d = '0;
        line_d = end_line ? '0 : pos_line + LW'(1);
      end else begin
        beat_d = pos_beat + BW'(1);
        line_d = pos_line;
      end
      if (end_beat && end_line) state_d = enable_i ? S_WAIT_SOF : S_IDLE;
      // A simultaneous read frees the slot, so a full buffer only overflows without one.
      if (full && !rd_fire) begin
        ovf_evt = 1'b1;
        if (DROP_EN) state_d = S_DROP;
      end else begin
        wr_en = 1'b1;
      end
    end
  end

  always_comb begin
    overflow_d  = overflow_q | ovf_evt;
    frame_cnt_d = frame_cnt_q;
    if (rd_fire && head[0]) frame_cnt_d = frame_cnt_q + 16'd1;
    if (clr_i) begin
      overflow_d  = 1'b0;
      frame_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      line_q      <= '0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_en, rd_fire})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : head[50:3];
  assign m_axis_tuser  = !empty && head[2];
  assign m_axis_tlast  = !empty && head[1];
  assign busy_o        = (state_q != S_IDLE);
  assign overflow_o    = overflow_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_axis_video_frame_ctrl.sv
// Bench for axis_video_frame_ctrl: vector table, directed corner sequences and
// randomized traffic against a frame-position reference model.
module tb_axis_video_frame_ctrl;
  localparam int LB    = 4;
  localparam int FL    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = LB * FL;
  localparam int W     = 51;

`ifdef AXIS_FRAME_DROP_EN
  localparam bit DROP_MODE = 1'b1;
`else
  localparam bit DROP_MODE = 1'b0;
`endif

  localparam int M_IDLE = 0, M_WAIT = 1, M_STREAM = 2, M_DROP = 3;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        enable_i, sof_i, pix_valid_i, clr_i, m_axis_tready;
  logic [47:0] pix_data_i;
  logic [47:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy_o, overflow_o;
  logic [15:0] frame_cnt_o;
  logic [1:0]  state_o;

  axis_video_frame_ctrl #(
    .LINE_BEATS (LB),
    .FRAME_LINES(FL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n_i),
    .enable_i     (enable_i),
    .sof_i        (sof_i),
    .pix_data_i   (pix_data_i),
    .pix_valid_i  (pix_valid_i),
    .clr_i        (clr_i),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o),
    .frame_cnt_o  (frame_cnt_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    bit          sof;
    bit          valid;
    logic [47:0] data;
    bit          ready;
    bit          exp_valid;
    logic [47:0] exp_data;
    bit          exp_user;
    bit          exp_last;
    logic [15:0] exp_fc;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: expected buffer contents {data, tuser, tlast, eof} plus frame position
  logic [W-1:0] exp_q[$];
  int           m_mode;
  int           m_idx;
  bit           m_ovf;
  logic [15:0]  m_fc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_mode = M_IDLE;
    m_idx  = 0;
    m_ovf  = 1'b0;
    m_fc   = '0;
  endtask

  task automatic model_update(input bit en, input bit sof, input bit valid,
                              input logic [47:0] data, input bit ready, input bit clr);
    bit           pop, take, push;
    int           pos;
    logic [W-1:0] ent, hd;
    pop  = (exp_q.size() != 0) && ready;
    take = 1'b0;
    push = 1'b0;
    pos  = 0;
    ent  = '0;
    case (m_mode)
      M_IDLE: if (en) m_mode = M_WAIT;
      M_WAIT: begin
        if (!en) m_mode = M_IDLE;
        else if (sof && valid) take = 1'b1;
      end
      M_STREAM: if (valid) begin take = 1'b1; pos = sof ? 0 : m_idx; end
      default: begin
        if (sof && valid) begin
          if (en) take = 1'b1;
          else m_mode = M_IDLE;
        end
      end
    endcase
    if (take) begin
      ent    = {data, pos == 0, (pos % LB) == LB - 1, pos == FRAME - 1};
      m_mode = M_STREAM;
      m_idx  = pos + 1;
      if (pos == FRAME - 1) begin
        m_mode = en ? M_WAIT : M_IDLE;
        m_idx  = 0;
      end
      if (exp_q.size() == DEPTH && !pop) begin
        m_ovf = 1'b1;
        if (DROP_MODE) m_mode = M_DROP;
      end else begin
        push = 1'b1;
      end
    end
    if (pop) begin
      hd = exp_q.pop_front();
      if (hd[0]) m_fc = m_fc + 16'd1;
    end
    if (push) exp_q.push_back(ent);
    if (clr) begin
      m_ovf = 1'b0;
      m_fc  = '0;
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] hd;
    check("tvalid", m_axis_tvalid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      hd = exp_q[0];
      check("tdata", m_axis_tdata, hd[50:3]);
      check("tuser", m_axis_tuser, hd[2]);
      check("tlast", m_axis_tlast, hd[1]);
    end
    check("busy", busy_o, m_mode != M_IDLE);
    check("overflow", overflow_o, m_ovf);
    check("frame_cnt", frame_cnt_o, m_fc);
  endtask

  // Called just after a falling edge; applies inputs for one rising edge.
  task automatic step(input bit en, input bit sof, input bit valid,
                      input logic [47:0] data, input bit ready, input bit clr);
    enable_i      = en;
    sof_i         = sof;
    pix_valid_i   = valid;
    pix_data_i    = data;
    m_axis_tready = ready;
    clr_i         = clr;
    @(posedge clk);
    model_update(en, sof, valid, data, ready, clr);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
    check({tag, "_tdata"}, m_axis_tdata, 48'h0);
    check({tag, "_tuser"}, m_axis_tuser, 1'b0);
    check({tag, "_tlast"}, m_axis_tlast, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_overflow"}, overflow_o, 1'b0);
    check({tag, "_frame_cnt"}, frame_cnt_o, 16'h0);
  endtask

  task automatic do_reset();
    reset_n_i     = 1'b0;
    enable_i      = 1'b0;
    sof_i         = 1'b0;
    pix_valid_i   = 1'b0;
    pix_data_i    = '0;
    m_axis_tready = 1'b0;
    clr_i         = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_n_i = 1'b1;
  endtask

  initial begin
    vec_t        tbl[10];
    logic [63:0] r;

    for (int i = 0; i < 10; i++) begin
      tbl[i].en        = 1'b1;
      tbl[i].sof       = (i == 1);
      tbl[i].valid     = (i >= 1) && (i <= 8);
      tbl[i].data      = 48'(100 + i);
      tbl[i].ready     = 1'b1;
      tbl[i].exp_valid = tbl[i].valid;
      tbl[i].exp_data  = 48'(100 + i);
      tbl[i].exp_user  = (i == 1);
      tbl[i].exp_last  = (i == 4) || (i == 8);
      tbl[i].exp_fc    = (i == 9) ? 16'd1 : 16'd0;
    end

    do_reset();

    // One full 4x2 frame with free-flowing output
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].en, tbl[i].sof, tbl[i].valid, tbl[i].data, tbl[i].ready, 1'b0);
      check("tbl_valid", m_axis_tvalid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        check("tbl_data", m_axis_tdata, tbl[i].exp_data);
        check("tbl_user", m_axis_tuser, tbl[i].exp_user);
        check("tbl_last", m_axis_tlast, tbl[i].exp_last);
      end
      check("tbl_frame_cnt", frame_cnt_o, tbl[i].exp_fc);
    end

    // Output stalled for 10 cycles under continuous input
    do_reset();
    step(1, 0, 0, '0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, i == 0, 1, 48'(200 + i), i >= 10, 0);
      if (i == 9) begin
        check("stall_overflow", overflow_o, 1'b1);
        check("stall_head", m_axis_tdata, 48'd200);
      end
    end
    repeat (6) step(1, 0, 0, '0, 1, 0);

    // sof at beat 2 of line 1 restarts the frame position
    do_reset();
    step(1, 0, 0, '0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, i == 0, 1, 48'(300 + i), 1, 0);
    step(1, 1, 1, 48'h777, 1, 0);
    check("restart_tuser", m_axis_tuser, 1'b1);
    check("restart_tdata", m_axis_tdata, 48'h777);
    for (int i = 1; i <= 3; i++) step(1, 0, 1, 48'(400 + i), 1, 0);
    check("restart_tlast", m_axis_tlast, 1'b1);
    repeat (8) step(1, 0, 1, 48'h500, 1, 0);

    // enable dropped mid-frame: the frame completes, then sof is ignored
    do_reset();
    step(1, 0, 0, '0, 1, 0);
    for (int i = 0; i < FRAME; i++) step(i < 3, i == 0, 1, 48'(500 + i), 1, 0);
    check("disable_idle", busy_o, 1'b0);
    step(0, 1, 1, 48'h999, 1, 0);
    check("disable_sof_ignored", m_axis_tvalid, 1'b0);
    check("disable_frame_cnt", frame_cnt_o, 16'd1);
    step(0, 0, 0, '0, 1, 0);
    check("disable_still_idle", busy_o, 1'b0);

    // Asynchronous reset with three beats buffered
    do_reset();
    step(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, i == 0, 1, 48'(600 + i), 0, 0);
    check("buffered_tvalid", m_axis_tvalid, 1'b1);
    #2 reset_n_i = 1'b0;
    #1 check_reset_values("async");
    model_reset();
    enable_i      = 1'b0;
    sof_i         = 1'b0;
    pix_valid_i   = 1'b0;
    m_axis_tready = 1'b0;
    @(negedge clk);
    reset_n_i = 1'b1;
    repeat (3) step(1, 0, 0, '0, 1, 0);
    for (int i = 0; i < FRAME; i++) step(1, i == 0, 1, 48'(700 + i), 1, 0);
    step(1, 0, 0, '0, 1, 0);
    check("pre_clr_frame_cnt", frame_cnt_o, 16'd1);
    for (int i = 0; i < 6; i++) step(1, i == 0, 1, 48'(800 + i), 0, 0);
    check("pre_clr_overflow", overflow_o, 1'b1);
    step(1, 0, 0, '0, 0, 1);
    check("clr_overflow", overflow_o, 1'b0);
    check("clr_frame_cnt", frame_cnt_o, 16'd0);
    repeat (8) step(1, 0, 0, '0, 1, 0);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom, $urandom};
      step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           r[47:0], $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end
    repeat (8) step(1, 0, 0, '0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
